// File: rtl/oam_pkg.sv
// Shared sizing, state encoding and address helpers for the OAM entry store.
package oam_pkg;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned HALVES  = 2;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned ENTRY_W = HALVES * HALF_W;
  localparam int unsigned RA_W    = $clog2(ENTRIES);
  localparam int unsigned WA_W    = $clog2(ENTRIES * HALVES);
  localparam int unsigned HA_W    = $clog2(HALVES);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } oam_state_t;

  typedef struct packed {
    logic [RA_W-1:0] entry;
    logic [HA_W-1:0] half;
  } oam_waddr_t;

  // Halfword address -> (entry, half); HALVES is a power of two so this is a bit split.
  function automatic oam_waddr_t split_addr(input logic [WA_W-1:0] addr);
    oam_waddr_t s;
    s.entry = addr[WA_W-1:HA_W];
    s.half  = addr[HA_W-1:0];
    return s;
  endfunction

endpackage

// File: rtl/oam_entry_store_if.sv
// CPU write / renderer read bus of the OAM entry store.
interface oam_entry_store_if;
  import oam_pkg::*;

  logic               wr_en;
  logic [WA_W-1:0]    wr_addr;
  logic [HALF_W-1:0]  wr_data;
  logic               wr_flush;
  logic               wr_ready;
  logic               clear_req;
  logic               busy;
  logic               rd_en;
  logic [RA_W-1:0]    rd_addr;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_flush, clear_req, rd_en, rd_addr,
    input  wr_ready, busy, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_flush, clear_req, rd_en, rd_addr,
    output wr_ready, busy, rd_valid, rd_data
  );
endinterface

// File: rtl/oam_be_ram.sv
// Simple dual-port RAM with per-lane write enables and a registered read-first read port.
module oam_be_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES-1:0]          we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [LANES*LANE_W-1:0]   wdata,
  input  logic                      re,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
    end
  end

  // Output register: resettable, holds between reads, sees pre-write contents.
  always_ff @(posedge clk) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/oam_entry_store.sv
// OAM store: stages CPU halfwords and commits whole entries atomically; clear sequencer; registered reads.
module oam_entry_store
  import oam_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  oam_entry_store_if.slave    bus
);

  oam_state_t                   state, state_nxt;
  logic [RA_W-1:0]              clr_ptr, clr_ptr_nxt;
  logic [RA_W-1:0]              stage_idx, stage_idx_nxt;
  logic [HALVES-1:0][HALF_W-1:0] stage_data, stage_data_nxt;
  logic [HALVES-1:0]            stage_mask, stage_mask_nxt;
  logic                         rd_valid_q;

  logic [HALVES-1:0]            ram_we;
  logic [RA_W-1:0]              ram_waddr;
  logic [HALVES-1:0][HALF_W-1:0] ram_wdata;
  logic                         ram_re;
  logic [ENTRY_W-1:0]           ram_rdata;
  oam_waddr_t                   wa;
  logic [HALVES-1:0]            half_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr    <= '0;
      stage_idx  <= '0;
      stage_data <= '0;
      stage_mask <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_ptr    <= clr_ptr_nxt;
      stage_idx  <= stage_idx_nxt;
      stage_data <= stage_data_nxt;
      stage_mask <= stage_mask_nxt;
      rd_valid_q <= ram_re;
    end
  end

  // Next state, staging and the single RAM write port.
  always_comb begin
    wa             = split_addr(bus.wr_addr);
    half_bit       = '0;
    half_bit[wa.half] = 1'b1;
    state_nxt      = state;
    clr_ptr_nxt    = clr_ptr;
    stage_idx_nxt  = stage_idx;
    stage_data_nxt = stage_data;
    stage_mask_nxt = stage_mask;
    ram_we         = '0;
    ram_waddr      = stage_idx;
    ram_wdata      = stage_data;
    case (state)
      CLEAR: begin
        ram_we      = '1;
        ram_waddr   = clr_ptr;
        ram_wdata   = '0;
        clr_ptr_nxt = clr_ptr + RA_W'(1);
        if (clr_ptr == RA_W'(ENTRIES - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (bus.clear_req) begin
          stage_mask_nxt = '0;
          clr_ptr_nxt    = '0;
          state_nxt      = CLEAR;
        end else if (bus.wr_en && (stage_mask != '0) && (wa.entry != stage_idx)) begin
          // Moving to another entry: retire the old stage, start a fresh one.
          ram_we                 = stage_mask;
          stage_idx_nxt          = wa.entry;
          stage_mask_nxt         = half_bit;
          stage_data_nxt[wa.half] = bus.wr_data;
        end else if (bus.wr_en) begin
          stage_idx_nxt          = wa.entry;
          stage_data_nxt[wa.half] = bus.wr_data;
          stage_mask_nxt         = stage_mask | half_bit;
          if ((wa.half == HA_W'(HALVES - 1)) || bus.wr_flush) begin
            ram_we         = stage_mask | half_bit;
            ram_waddr      = wa.entry;
            ram_wdata      = stage_data_nxt;
            stage_mask_nxt = '0;
          end
        end else if (bus.wr_flush && (stage_mask != '0)) begin
          ram_we         = stage_mask;
          stage_mask_nxt = '0;
        end
      end
    endcase
    if (!reset) ram_we = '0;
  end

  assign ram_re = bus.rd_en && (state == IDLE);

  oam_be_ram #(
    .DEPTH  (ENTRIES),
    .LANES  (HALVES),
    .LANE_W (HALF_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (bus.rd_addr),
    .rdata (ram_rdata)
  );

  assign bus.busy     = (state == CLEAR);
  assign bus.wr_ready = (state == IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = ram_rdata;

endmodule

// File: tb/tb_oam_entry_store.sv
// Bench for oam_entry_store: directed scenarios plus random traffic against an entry-level model.
module tb_oam_entry_store;
  import oam_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_entry_store_if bus();

  oam_entry_store #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference: committed entries plus the pending partial entry.
  logic [ENTRY_W-1:0] mref [ENTRIES];
  int                 st_idx;
  bit                 st_mask [HALVES];
  logic [HALF_W-1:0]  st_h [HALVES];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_flush  = 1'b0;
    bus.clear_req = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
  endtask

  function automatic void model_clear();
    for (int e = 0; e < int'(ENTRIES); e++) mref[e] = '0;
    for (int h = 0; h < int'(HALVES); h++) st_mask[h] = 1'b0;
  endfunction

  function automatic bit model_staged();
    bit any = 1'b0;
    for (int h = 0; h < int'(HALVES); h++) any |= st_mask[h];
    return any;
  endfunction

  function automatic void model_commit();
    for (int h = 0; h < int'(HALVES); h++) begin
      if (st_mask[h]) mref[st_idx][h*HALF_W +: HALF_W] = st_h[h];
      st_mask[h] = 1'b0;
    end
  endfunction

  // One IDLE cycle of the store; returns what a read this cycle must deliver.
  function automatic logic [ENTRY_W-1:0] model_cycle(input bit we, input int a, input logic [HALF_W-1:0] d,
                                                      input bit fl, input bit cr, input int ra);
    logic [ENTRY_W-1:0] rd;
    int e, h;
    rd = mref[ra];
    e  = a / int'(HALVES);
    h  = a % int'(HALVES);
    if (cr) begin
      model_clear();
    end else if (we) begin
      if (model_staged() && e != st_idx) begin
        model_commit();
        st_idx = e; st_h[h] = d; st_mask[h] = 1'b1;
      end else begin
        st_idx = e; st_h[h] = d; st_mask[h] = 1'b1;
        if (h == int'(HALVES) - 1 || fl) model_commit();
      end
    end else if (fl) begin
      model_commit();
    end
    return rd;
  endfunction

  task automatic drive(input bit we, input int a, input logic [HALF_W-1:0] d, input bit fl,
                       input bit cr, input bit re, input int ra, output logic [ENTRY_W-1:0] exp_rd);
    bus.wr_en     = we;
    bus.wr_addr   = WA_W'(a);
    bus.wr_data   = d;
    bus.wr_flush  = fl;
    bus.clear_req = cr;
    bus.rd_en     = re;
    bus.rd_addr   = RA_W'(ra);
    exp_rd        = model_cycle(we, a, d, fl, cr, ra);
  endtask

  task automatic test_reset();
    int n;
    bit rv_seen;
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      fails++; $display("FAIL reset_outputs: rd_valid=%b rd_data=%h, want 0/0", bus.rd_valid, bus.rd_data);
    end
    tests++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
      fails++; $display("FAIL reset_state: busy=%b wr_ready=%b, want 1/0", bus.busy, bus.wr_ready);
    end
    reset = 1'b1;
    model_clear();
    // Requests during the clear must be ignored.
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.wr_flush = 1'b1; bus.wr_data = 16'hDEAD;
    n = 0; rv_seen = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      tick();
      if (bus.rd_valid === 1'b1) rv_seen = 1'b1;
    end
    idle_inputs();
    tests++;
    if (n != 64) begin
      fails++; $display("FAIL reset_clear_len: busy cycles=%0d, want 64", n);
    end
    tests++;
    if (rv_seen || bus.wr_ready !== 1'b1) begin
      fails++; $display("FAIL reset_clear_ignore: rd_valid_seen=%b wr_ready=%b, want 0/1", rv_seen, bus.wr_ready);
    end
  endtask

  task automatic test_read_all_zero();
    logic [ENTRY_W-1:0] exp_rd;
    for (int e = 0; e < int'(ENTRIES); e++) begin
      drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, e, exp_rd);
      tick();
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h0) begin
        fails++; $display("FAIL zero_read e=%0d: valid=%b data=%h, want 1/00000000", e, bus.rd_valid, bus.rd_data);
      end
    end
    idle_inputs();
    tick();
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin
      fails++; $display("FAIL zero_read_hold: valid=%b data=%h, want 0/00000000", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_commit();
    logic [ENTRY_W-1:0] exp_rd;
    drive(1'b1, 10, 16'h1234, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b1, 11, 16'hABCD, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 5, exp_rd); tick();
    tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hABCD1234) begin
      fails++; $display("FAIL full_commit: valid=%b data=%h, want 1/abcd1234", bus.rd_valid, bus.rd_data);
    end
    drive(1'b1, 10, 16'h5555, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 5, exp_rd); tick();
    tests++;
    if (bus.rd_data !== 32'hABCD1234) begin
      fails++; $display("FAIL staged_hidden: data=%h, want abcd1234", bus.rd_data);
    end
    drive(1'b1, 20, 16'h0BEE, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 5, exp_rd); tick();
    tests++;
    if (bus.rd_data !== 32'hABCD5555) begin
      fails++; $display("FAIL partial_commit: data=%h, want abcd5555", bus.rd_data);
    end
    idle_inputs();
    tick();
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'hABCD5555) begin
      fails++; $display("FAIL rd_hold: valid=%b data=%h, want 0/abcd5555", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_flush();
    logic [ENTRY_W-1:0] exp_rd;
    drive(1'b1, 2, 16'h00FF, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b1, 2, 16'h01FF, 1'b1, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 1, exp_rd); tick();
    tests++;
    if (bus.rd_data !== 32'h000001FF) begin
      fails++; $display("FAIL flush_with_write: data=%h, want 000001ff", bus.rd_data);
    end
    drive(1'b1, 6, 16'h6666, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b1, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 3, exp_rd); tick();
    tests++;
    if (bus.rd_data !== 32'h00006666) begin
      fails++; $display("FAIL flush_alone: data=%h, want 00006666", bus.rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_read_first();
    logic [ENTRY_W-1:0] exp_rd;
    drive(1'b1, 14, 16'h7777, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b1, 15, 16'h8888, 1'b0, 1'b0, 1'b1, 7, exp_rd); tick();
    tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h00000000) begin
      fails++; $display("FAIL read_first_old: valid=%b data=%h, want 1/00000000", bus.rd_valid, bus.rd_data);
    end
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 7, exp_rd); tick();
    tests++;
    if (bus.rd_data !== 32'h88887777) begin
      fails++; $display("FAIL read_first_new: data=%h, want 88887777", bus.rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_clear_req();
    logic [ENTRY_W-1:0] exp_rd;
    int n;
    drive(1'b1, 6, 16'h3333, 1'b0, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b1, 7, 16'h4444, 1'b1, 1'b1, 1'b1, 5, exp_rd); tick();
    tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hABCD5555) begin
      fails++; $display("FAIL clear_cycle_read: valid=%b data=%h, want 1/abcd5555", bus.rd_valid, bus.rd_data);
    end
    idle_inputs();
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin n++; tick(); end
    tests++;
    if (n != 64) begin
      fails++; $display("FAIL clear_req_len: busy cycles=%0d, want 64", n);
    end
    drive(1'b0, 0, '0, 1'b1, 1'b0, 1'b0, 0, exp_rd); tick();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 3, exp_rd); tick();
    tests++;
    if (bus.rd_data !== 32'h0) begin
      fails++; $display("FAIL clear_discard: data=%h, want 00000000", bus.rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    logic [ENTRY_W-1:0] exp_rd;
    int n;
    drive(1'b0, 0, '0, 1'b0, 1'b1, 1'b0, 0, exp_rd); tick();
    idle_inputs();
    for (int i = 0; i < 30; i++) tick();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    model_clear();
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin n++; tick(); end
    tests++;
    if (n != 64) begin
      fails++; $display("FAIL reset_mid_clear_len: busy cycles=%0d, want 64", n);
    end
  endtask

  task automatic test_random();
    logic [ENTRY_W-1:0] exp_rd, hold;
    bit we, fl, re;
    int a, ra, bad;
    hold = '0; bad = 0;
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      re = (i == 0) || ($urandom_range(0, 1) == 1);
      a  = int'($urandom_range(0, 15));
      ra = int'($urandom_range(0, 7));
      drive(we, a, HALF_W'($urandom), fl, 1'b0, re, ra, exp_rd);
      tick();
      tests++;
      if (re) begin
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rd) begin
          fails++; bad++;
          if (bad < 10) $display("FAIL random_read i=%0d e=%0d: valid=%b data=%h, want 1/%h", i, ra, bus.rd_valid, bus.rd_data, exp_rd);
        end
        hold = exp_rd;
      end else if (bus.rd_valid !== 1'b0 || bus.rd_data !== hold) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL random_hold i=%0d: valid=%b data=%h, want 0/%h", i, bus.rd_valid, bus.rd_data, hold);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    st_idx = 0;
    for (int h = 0; h < int'(HALVES); h++) begin st_mask[h] = 1'b0; st_h[h] = '0; end
    test_reset();
    test_read_all_zero();
    test_commit();
    test_flush();
    test_read_first();
    test_clear_req();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
